// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state, SPI mode encodings and default word width.
package spi_pkg;
  typedef enum logic [1:0] {IDLE, ACTIVE, WAIT_DESEL} state_e;
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;
  localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/spi_sync.sv
// spi_sync: multi-flop single-bit synchroniser into the clk domain.
module spi_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic din,
  output logic dout
);
  logic [STAGES-1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[STAGES-2:0], din};
  always_ff @(posedge clk) sync_q <= sync_d;
  assign dout = sync_q[STAGES-1];
endmodule

// File: rtl/spi_slave_os.sv
// spi_slave_os: oversampling SPI slave, all CPOL/CPHA modes, MSB-first, one-word tx buffer.
module spi_slave_os
  import spi_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpol,
  input  logic             cpha,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             underrun
);
  localparam int CW = $clog2(WIDTH + 1);
  state_e state_q, state_d;
  logic sclk_s, cs_s, mosi_s, sclk_p_q, cs_p_q;
  logic cpol_q, cpol_d, cpha_q, cpha_d, miso_q, miso_d, need_q, need_d;
  logic zload_q, zload_d, under_q, under_d, rxv_q, rxv_d, bufv_q, bufv_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] so_q, so_d, rsh_q, rsh_d, rxd_q, rxd_d, buf_q, buf_d, word, rx_next;
  logic sedge, lead, trail, cs_fall, start, run, samp, shft, word_end, load, accept, consume;

  spi_sync #(.STAGES(SYNC_STAGES)) u_sclk (.clk(clk), .din(sclk), .dout(sclk_s));
  spi_sync #(.STAGES(SYNC_STAGES)) u_cs   (.clk(clk), .din(cs_n), .dout(cs_s));
  spi_sync #(.STAGES(SYNC_STAGES)) u_mosi (.clk(clk), .din(mosi), .dout(mosi_s));

  always_ff @(posedge clk) begin
    sclk_p_q <= sclk_s;
    cs_p_q   <= cs_s;
  end

  always_ff @(posedge clk)
    state_q <= reset ? (cs_s ? IDLE : WAIT_DESEL) : state_d;

  always_comb
    state_d = (state_q == IDLE) ? (cs_fall ? ACTIVE : IDLE) : (cs_s ? IDLE : state_q);

  always_comb begin
    busy     = state_q == ACTIVE;
    miso     = miso_q;
    tx_ready = ~bufv_q;
    rx_data  = rxd_q;
    rx_valid = rxv_q;
    underrun = under_q;
  end

  // A word's shift-out is loaded on its first driving edge; the underrun flag waits for
  // that word's first sample so a trailing edge after the frame's last word is harmless.
  always_comb begin
    sedge    = sclk_s ^ sclk_p_q;
    lead     = sedge & (sclk_s != cpol_q);
    trail    = sedge & (sclk_s == cpol_q);
    cs_fall  = cs_p_q & ~cs_s;
    start    = (state_q == IDLE) & cs_fall;
    run      = (state_q == ACTIVE) & ~cs_s;
    samp     = run & (cpha_q ? trail : lead);
    shft     = run & (cpha_q ? lead : trail);
    word_end = samp & (cnt_q == CW'(WIDTH - 1));
    load     = (start & ~cpha) | (shft & need_q);
    word     = bufv_q ? buf_q : '0;
    accept   = tx_load & ~bufv_q;
    consume  = load & bufv_q;
    rx_next  = {rsh_q[WIDTH-2:0], mosi_s};
    cpol_d   = start ? cpol : cpol_q;
    cpha_d   = start ? cpha : cpha_q;
    so_d     = load ? word << 1 : shft ? so_q << 1 : so_q;
    miso_d   = load ? word[WIDTH-1] : shft ? so_q[WIDTH-1] : run ? miso_q : 1'b0;
    need_d   = start ? cpha : run ? (word_end | (need_q & ~shft)) : 1'b0;
    zload_d  = load ? ~bufv_q : (run & ~samp) ? zload_q : 1'b0;
    under_d  = under_q | (samp & zload_q);
    cnt_d    = ~run ? '0 : word_end ? '0 : samp ? cnt_q + 1'b1 : cnt_q;
    rsh_d    = samp ? rx_next : rsh_q;
    rxd_d    = word_end ? rx_next : rxd_q;
    rxv_d    = word_end;
    buf_d    = accept ? tx_data : buf_q;
    bufv_d   = accept | (bufv_q & ~consume);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      miso_q  <= 1'b0;
      need_q  <= 1'b0;
      zload_q <= 1'b0;
      under_q <= 1'b0;
      rxv_q   <= 1'b0;
      bufv_q  <= 1'b0;
      cnt_q   <= '0;
      so_q    <= '0;
      rsh_q   <= '0;
      rxd_q   <= '0;
      buf_q   <= '0;
    end else begin
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      miso_q  <= miso_d;
      need_q  <= need_d;
      zload_q <= zload_d;
      under_q <= under_d;
      rxv_q   <= rxv_d;
      bufv_q  <= bufv_d;
      cnt_q   <= cnt_d;
      so_q    <= so_d;
      rsh_q   <= rsh_d;
      rxd_q   <= rxd_d;
      buf_q   <= buf_d;
    end
  end
endmodule

// File: doc/spi_slave_os.md
# spi_slave_os

Oversampling SPI slave endpoint; the peer that consumes the master's `mosi`/chip-select stream and returns `miso`. It runs entirely in the system `clk` domain, synchronising `sclk`, `cs_n` and `mosi`, and detecting `sclk` edges internally. It supports all four CPOL/CPHA modes, MSB-first, with a one-word transmit buffer (valid/ready) and a one-cycle receive strobe toward the local register file.

## Interface
- `WIDTH`, 8, word length in bits
- `SYNC_STAGES`, 2, flops per input synchroniser (min 2)

- `clk` in 1, system clock
- `reset` in 1, reset, synchronous, active-high
- `cpol` in 1, clock idle level; sampled at frame start
- `cpha` in 1, clock phase; sampled at frame start
- `sclk` in 1, SPI clock from master, asynchronous
- `cs_n` in 1, chip select from master (master's cs0/cs1/cs2), active-low, asynchronous
- `mosi` in 1, serial data from master, asynchronous
- `miso` out 1, serial data to master
- `tx_data` in WIDTH, next word to transmit
- `tx_load` in 1, tx_data valid
- `tx_ready` out 1, transmit buffer empty
- `rx_data` out WIDTH, last complete received word
- `rx_valid` out 1, one-cycle strobe: rx_data updated
- `busy` out 1, frame in progress
- `underrun` out 1, sticky: a word was started with empty tx buffer

## Operation
- Reset values: `miso`=0, `tx_ready`=1, `rx_data`=0, `rx_valid`=0, `busy`=0, `underrun`=0; tx buffer empty, state IDLE, bit counter 0.
- Synchronised signals: `sclk_s`, `cs_s`, `mosi_s`. Leading edge = `sclk_s` leaves `cpol_q`; trailing edge = returns to `cpol_q`.
- States: IDLE, ACTIVE, WAIT_DESEL.
  - IDLE -> ACTIVE on `cs_s` falling: latch `cpol_q`/`cpha_q`, load shift-out register from tx buffer (buffer -> empty), counter=0, `busy`=1.
  - ACTIVE -> IDLE on `cs_s` rising: abort, partial word discarded, no `rx_valid`, `miso`=0, `busy`=0.
  - WAIT_DESEL: entered if reset released while `cs_s`=0; ignores all edges; -> IDLE on `cs_s` high.
- cpha=0: `miso` drives shift-out MSB immediately at frame start; sample `mosi_s` on leading edge; shift out on trailing edge.
- cpha=1: shift out (drive next bit) on leading edge; sample on trailing edge.
- Each sample shifts `mosi_s` into rx shift register LSB, counter+1. On WIDTH-th sample: `rx_data` <= full word, `rx_valid`=1 for one cycle, counter wraps to 0, shift-out reloaded from tx buffer for next word (continuous frames allowed).
- Word load with empty tx buffer: shift-out loaded with all zeros, `underrun` set (sticky until reset).
- tx handshake: transfer when `tx_load` && `tx_ready`; `tx_ready` drops next cycle; rises the cycle after buffer is consumed. `tx_load` while `tx_ready`=0 ignored.
- Same-cycle tx accept and word load with empty buffer: load sees empty (underrun, zeros), accepted data goes to buffer for the following word.
- `miso`=0 whenever not ACTIVE.

## Timing
- Input-to-action latency: SYNC_STAGES+1 `clk` cycles from pin edge to internal edge strobe.
- `rx_valid` asserts SYNC_STAGES+1 cycles after the WIDTH-th sampling pin edge.
- `miso` update: SYNC_STAGES+1 cycles after the driving pin edge; master must sample ≥1 half-period later.
- Requirement: each `sclk` half-period ≥ SYNC_STAGES+2 `clk` cycles; `cs_n` setup to first edge same bound.
- `cpol`/`cpha` changes mid-frame have no effect.
- Reset mid-frame: all outputs to reset values next cycle; WAIT_DESEL if `cs_s` low.

## Structure
- Package `spi_pkg`: state enum typedef (IDLE, ACTIVE, WAIT_DESEL), mode constants MODE0..MODE3 as {cpol,cpha}, default WIDTH.
- Sub-module `spi_sync` (SYNC_STAGES-deep single-bit synchroniser), instantiated for `sclk`, `cs_n`, `mosi`.
- Top holds edge detect, FSM, counter, shift registers, tx buffer.

## Test plan
- Mode 0, tx buffer 0x3C, master sends 0xA5 -> `rx_data`=0xA5 with single `rx_valid`, master receives 0x3C, `underrun`=0.
- Mode 3, two back-to-back words 0x81, 0x7E, tx 0x11 then 0x22 loaded via handshake -> two `rx_valid` pulses in order, master receives 0x11, 0x22.
- Modes 1 and 2, same 0xC3 exchange -> identical rx/tx results to mode 0.
- `cs_n` deasserted after 5 bits -> no `rx_valid`, `rx_data` unchanged, `busy`=0, next frame receives full word correctly.
- Frame with empty tx buffer -> master receives 0x00, `underrun`=1 and stays 1 until reset.
- `reset` pulsed mid-frame with `cs_n` low -> outputs at reset values, remaining edges ignored until `cs_n` high; next frame correct.
